// File: rtl/recirc_pkg.sv
// Shared definitions for the recirculating lane router.
// Provides the mode encodings and a lane popcount helper sized for up to
// MAX_LANES lanes; callers zero-extend narrower lane vectors.
package recirc_pkg;

    localparam int unsigned MAX_LANES = 8;
    localparam int unsigned POP_W     = 4;

    typedef enum logic [1:0] {
        MODE_ACTIVE = 2'd0,
        MODE_DRAIN  = 2'd1,
        MODE_IDLE   = 2'd2
    } mode_e;

    // Number of set bits among the low num_lanes bits of vec.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_LANES-1:0] vec,
                                                  input int unsigned          num_lanes);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if ((i < num_lanes) && vec[i]) begin
                cnt = cnt + POP_W'(1);
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/recirc_lane_skid.sv
// One forward-path lane: registered output stage plus a one-entry skid buffer.
// Ports: clk/reset (sync, high); route_en enables accepting new words;
// valid_in/data_in upstream word; fwd_ready shared downstream accept;
// in_ready_c = skid empty; fwd_valid/fwd_data registered output;
// empty_next_c = lane holds nothing once this cycle's updates land.
module recirc_lane_skid #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              route_en,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fwd_ready,
    output logic              in_ready_c,
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
    output logic              empty_next_c
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              skid_full_q, skid_full_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              accept;
    logic              out_load;

    // Output stage refills from the skid first so per-lane order is kept.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        in_ready_c  = ~skid_full_q;
        accept      = route_en & valid_in & ~skid_full_q;
        out_load    = ~out_valid_q | fwd_ready;

        if (out_load) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_data_q;
                skid_full_d = accept;
                if (accept) begin
                    skid_data_d = data_in;
                end
            end else begin
                out_valid_d = accept;
                if (accept) begin
                    out_data_d = data_in;
                end
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_data_d = data_in;
        end

        empty_next_c = ~out_valid_d & ~skid_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign fwd_valid = out_valid_q;
    assign fwd_data  = out_data_q;

endmodule

// File: rtl/recirc_router_param.sv
// Routes NUM_LANES valid-qualified lanes to a backpressured forward path or a
// registered recirculation path, selected by an ACTIVE/DRAIN/IDLE mode FSM.
// Ports: clk/reset (sync, high); idle_sel requests recirculation; data_in/
// valid_in/in_ready upstream; fwd_* forward path with shared fwd_ready;
// rec_* recirculation path; mode current state; cnt_clr clears the
// saturating fwd_count/rec_count word counters.
module recirc_router_param
    import recirc_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        idle_sel,
    input  logic [NUM_LANES*DATA_W-1:0] data_in,
    input  logic [NUM_LANES-1:0]        valid_in,
    output logic [NUM_LANES-1:0]        in_ready,
    output logic [NUM_LANES*DATA_W-1:0] fwd_data,
    output logic [NUM_LANES-1:0]        fwd_valid,
    input  logic                        fwd_ready,
    output logic [NUM_LANES*DATA_W-1:0] rec_data,
    output logic [NUM_LANES-1:0]        rec_valid,
    output logic [1:0]                  mode,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            fwd_count,
    output logic [CNT_W-1:0]            rec_count
);

    localparam int unsigned BUS_W = NUM_LANES * DATA_W;
    localparam int unsigned SUM_W = CNT_W + POP_W;

    mode_e                 state_q, state_d;
    logic [NUM_LANES-1:0]  rec_valid_q, rec_valid_d;
    logic [BUS_W-1:0]      rec_data_q,  rec_data_d;
    logic [CNT_W-1:0]      fwd_count_q, fwd_count_d;
    logic [CNT_W-1:0]      rec_count_q, rec_count_d;
    logic [NUM_LANES-1:0]  lane_ready_c;
    logic [NUM_LANES-1:0]  lane_empty_next_c;
    logic                  route_fwd;
    logic                  all_empty_next;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        return (s > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign route_fwd = (state_q == MODE_ACTIVE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        recirc_lane_skid #(.DATA_W(DATA_W)) u_lane (
            .clk          (clk),
            .reset        (reset),
            .route_en     (route_fwd),
            .valid_in     (valid_in[i]),
            .data_in      (data_in[i*DATA_W +: DATA_W]),
            .fwd_ready    (fwd_ready),
            .in_ready_c   (lane_ready_c[i]),
            .fwd_valid    (fwd_valid[i]),
            .fwd_data     (fwd_data[i*DATA_W +: DATA_W]),
            .empty_next_c (lane_empty_next_c[i])
        );
    end

    // Emptiness after this cycle's updates, so IDLE is only entered once the
    // forward path has nothing left to present.
    assign all_empty_next = &lane_empty_next_c;

    // Mode FSM, recirculation capture and counters.
    always_comb begin
        state_d     = state_q;
        rec_valid_d = '0;
        rec_data_d  = rec_data_q;
        fwd_count_d = fwd_count_q;
        rec_count_d = rec_count_q;
        in_ready    = route_fwd ? lane_ready_c : {NUM_LANES{1'b1}};

        unique case (state_q)
            MODE_ACTIVE: begin
                if (idle_sel) begin
                    state_d = all_empty_next ? MODE_IDLE : MODE_DRAIN;
                end
            end
            MODE_DRAIN: begin
                if (!idle_sel) begin
                    state_d = MODE_ACTIVE;
                end else if (all_empty_next) begin
                    state_d = MODE_IDLE;
                end
            end
            MODE_IDLE: begin
                if (!idle_sel) begin
                    state_d = MODE_ACTIVE;
                end
            end
            default: state_d = MODE_ACTIVE;
        endcase

        if (!route_fwd) begin
            rec_valid_d = valid_in;
            rec_data_d  = data_in;
        end

        if (cnt_clr) begin
            fwd_count_d = '0;
            rec_count_d = '0;
        end else begin
            fwd_count_d = sat_add(fwd_count_q,
                                  popcount(MAX_LANES'(fwd_valid & {NUM_LANES{fwd_ready}}), NUM_LANES));
            rec_count_d = sat_add(rec_count_q, popcount(MAX_LANES'(rec_valid_q), NUM_LANES));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= MODE_ACTIVE;
            rec_valid_q <= '0;
            rec_data_q  <= '0;
            fwd_count_q <= '0;
            rec_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rec_valid_q <= rec_valid_d;
            rec_data_q  <= rec_data_d;
            fwd_count_q <= fwd_count_d;
            rec_count_q <= rec_count_d;
        end
    end

    assign mode      = state_q;
    assign rec_valid = rec_valid_q;
    assign rec_data  = rec_data_q;
    assign fwd_count = fwd_count_q;
    assign rec_count = rec_count_q;

endmodule
